fft2d_4x4_ctrl: RTL and testbench

Sequencer for the 4x4 2D FFT. It streams in 16 real samples and runs the row pass and the column pass on one shared real-input 4-point FFT engine, which sits outside this block and is combinational. It then streams out 16 complex bins. The column pass does each complex 4-point transform as two real-input transforms plus a combine step, using FFT(re + j·im) = FFT(re) + j·FFT(im).

---
 rtl/fft2d_4x4_ctrl_if.sv | 25 ++
 rtl/fft2d_4x4_ctrl.sv | 139 +++++++++++++
 tb/tb_fft2d_4x4_ctrl.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/fft2d_4x4_ctrl_if.sv
// Stream interface for the 4x4 2D FFT sequencer: real samples in, complex bins out.
// Latency: none, wires only.
// Backpressure: valid/ready on both directions; the slave modport is the sequencer side.
interface fft2d_4x4_ctrl_if #(
    parameter int DATA_W = 16
);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_real;
    logic [DATA_W-1:0] out_imag;
    logic              out_last;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_real, out_imag, out_last
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_real, out_imag, out_last
    );
endinterface

// File: rtl/fft2d_4x4_ctrl.sv
// Sequencer for a 4x4 2D FFT on a shared external combinational real-input 4-point engine.
// Latency: first bin 24 cycles after the 16th sample is accepted (8-cycle row pass, 16-cycle column pass).
// Backpressure: in_ready only in LOAD; output held stable while out_valid & !out_ready. FFT2D_CTRL_SCALE_EN halves every buffer write.
module fft2d_4x4_ctrl #(
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    fft2d_4x4_ctrl_if.slave   strm,
    output logic              busy,
    output logic [DATA_W-1:0] eng_a0,
    output logic [DATA_W-1:0] eng_a1,
    output logic [DATA_W-1:0] eng_a2,
    output logic [DATA_W-1:0] eng_a3,
    input  logic [DATA_W-1:0] eng_g0_real,
    input  logic [DATA_W-1:0] eng_g1_real,
    input  logic [DATA_W-1:0] eng_g2_real,
    input  logic [DATA_W-1:0] eng_g3_real,
    input  logic [DATA_W-1:0] eng_g0_imag,
    input  logic [DATA_W-1:0] eng_g1_imag,
    input  logic [DATA_W-1:0] eng_g2_imag,
    input  logic [DATA_W-1:0] eng_g3_imag
);
    typedef enum logic [2:0] {
        LOAD, ROW_ISSUE, ROW_CAP, CRE_ISSUE, CRE_CAP, CIM_ISSUE, CIM_CAP, OUT
    } state_t;

    state_t            state, state_nxt;
    logic [3:0]        idx;
    logic [1:0]        r, c;
    logic [DATA_W-1:0] buf_re [4][4];
    logic [DATA_W-1:0] buf_im [4][4];
    logic [DATA_W-1:0] tr [4];
    logic [DATA_W-1:0] ti [4];
    logic [DATA_W-1:0] eng_a [4];
    logic [DATA_W-1:0] g_re [4];
    logic [DATA_W-1:0] g_im [4];
    logic              in_fire, out_fire;

    // Optional halving of every value written back into the buffer keeps full-scale input from wrapping.
    function automatic logic [DATA_W-1:0] scl(input logic [DATA_W-1:0] v);
`ifdef FFT2D_CTRL_SCALE_EN
        return $signed(v) >>> 1;
`else
        return v;
`endif
    endfunction

    assign g_re = '{eng_g0_real, eng_g1_real, eng_g2_real, eng_g3_real};
    assign g_im = '{eng_g0_imag, eng_g1_imag, eng_g2_imag, eng_g3_imag};
    assign eng_a0 = eng_a[0];
    assign eng_a1 = eng_a[1];
    assign eng_a2 = eng_a[2];
    assign eng_a3 = eng_a[3];
    assign in_fire  = strm.in_valid & strm.in_ready;
    assign out_fire = strm.out_valid & strm.out_ready;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= LOAD;
        else        state <= state_nxt;
    end

    // Next-state and handshake outputs; bin data is forced to zero outside OUT.
    always_comb begin
        state_nxt      = state;
        strm.in_ready  = 1'b0;
        strm.out_valid = 1'b0;
        strm.out_last  = 1'b0;
        strm.out_real  = '0;
        strm.out_imag  = '0;
        busy           = (state != LOAD);
        case (state)
            LOAD: begin
                strm.in_ready = 1'b1;
                if (in_fire && idx == 4'd15) state_nxt = ROW_ISSUE;
            end
            ROW_ISSUE: state_nxt = ROW_CAP;
            ROW_CAP:   state_nxt = (r == 2'd3) ? CRE_ISSUE : ROW_ISSUE;
            CRE_ISSUE: state_nxt = CRE_CAP;
            CRE_CAP:   state_nxt = CIM_ISSUE;
            CIM_ISSUE: state_nxt = CIM_CAP;
            CIM_CAP:   state_nxt = (c == 2'd3) ? OUT : CRE_ISSUE;
            OUT: begin
                strm.out_valid = 1'b1;
                strm.out_last  = (idx == 4'd15);
                strm.out_real  = buf_re[idx[3:2]][idx[1:0]];
                strm.out_imag  = buf_im[idx[3:2]][idx[1:0]];
                if (out_fire && idx == 4'd15) state_nxt = LOAD;
            end
            default:   state_nxt = LOAD;
        endcase
    end

    // Counters and engine operand registers; counters wrap to zero at the end of each pass.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx <= '0;
            r   <= '0;
            c   <= '0;
            for (int i = 0; i < 4; i++) eng_a[i] <= '0;
        end else begin
            case (state)
                LOAD:      if (in_fire) idx <= idx + 4'd1;
                ROW_ISSUE: for (int i = 0; i < 4; i++) eng_a[i] <= buf_re[r][i];
                ROW_CAP:   r <= r + 2'd1;
                CRE_ISSUE: for (int i = 0; i < 4; i++) eng_a[i] <= buf_re[i][c];
                CIM_ISSUE: for (int i = 0; i < 4; i++) eng_a[i] <= buf_im[i][c];
                CIM_CAP:   c <= c + 2'd1;
                OUT:       if (out_fire) idx <= idx + 4'd1;
                default:   ;
            endcase
        end
    end

    // In-place buffer and column temporaries; contents are don't-care after reset.
    always_ff @(posedge clk) begin
        case (state)
            LOAD: if (in_fire) begin
                buf_re[idx[3:2]][idx[1:0]] <= strm.in_data;
                buf_im[idx[3:2]][idx[1:0]] <= '0;
            end
            ROW_CAP: for (int k = 0; k < 4; k++) begin
                buf_re[r][k] <= scl(g_re[k]);
                buf_im[r][k] <= scl(g_im[k]);
            end
            CRE_CAP: for (int k = 0; k < 4; k++) begin
                tr[k] <= g_re[k];
                ti[k] <= g_im[k];
            end
            // FFT(re + j*im) = FFT(re) + j*FFT(im)
            CIM_CAP: for (int k = 0; k < 4; k++) begin
                buf_re[k][c] <= scl(tr[k] - g_im[k]);
                buf_im[k][c] <= scl(ti[k] + g_re[k]);
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_fft2d_4x4_ctrl.sv
// Bench for fft2d_4x4_ctrl with a behavioural real-input 4-point engine and a 2D DFT reference model.
// Latency: checks first out_valid lands 24 cycles after the last sample is accepted.
// Backpressure: toggles in_valid and stalls out_ready on beats 0, 7 and 15 for selected frames.
module tb_fft2d_4x4_ctrl;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        busy;
    logic [15:0] eng_a0, eng_a1, eng_a2, eng_a3;
    logic [15:0] eng_g0_real, eng_g1_real, eng_g2_real, eng_g3_real;
    logic [15:0] eng_g0_imag, eng_g1_imag, eng_g2_imag, eng_g3_imag;

    fft2d_4x4_ctrl_if #(.DATA_W(16)) sif ();

    fft2d_4x4_ctrl #(.DATA_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .strm(sif), .busy(busy),
        .eng_a0(eng_a0), .eng_a1(eng_a1), .eng_a2(eng_a2), .eng_a3(eng_a3),
        .eng_g0_real(eng_g0_real), .eng_g1_real(eng_g1_real),
        .eng_g2_real(eng_g2_real), .eng_g3_real(eng_g3_real),
        .eng_g0_imag(eng_g0_imag), .eng_g1_imag(eng_g1_imag),
        .eng_g2_imag(eng_g2_imag), .eng_g3_imag(eng_g3_imag)
    );

    always #5 clk = ~clk;

    // Real-input 4-point DFT: X[k] = sum a[n] * (-j)^(n*k), wrapping at 16 bits.
    assign eng_g0_real = eng_a0 + eng_a1 + eng_a2 + eng_a3;
    assign eng_g0_imag = 16'd0;
    assign eng_g1_real = eng_a0 - eng_a2;
    assign eng_g1_imag = eng_a3 - eng_a1;
    assign eng_g2_real = eng_a0 - eng_a1 + eng_a2 - eng_a3;
    assign eng_g2_imag = 16'd0;
    assign eng_g3_real = eng_a0 - eng_a2;
    assign eng_g3_imag = eng_a1 - eng_a3;

    typedef logic signed [15:0] vec_t [16];
    typedef struct {
        vec_t x;
        vec_t er;
        vec_t ei;
        bit   tog;
        bit   stall;
    } rec_t;
    typedef struct packed {
        logic [15:0] re;
        logic [15:0] im;
        logic        last;
    } beat_t;

    rec_t  recs [5];
    beat_t sb [$];
    int    n_chk  = 0;
    int    n_pass = 0;

    task automatic check(input string nm, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    endtask

    function automatic logic signed [15:0] sc16(input int v);
        logic signed [15:0] t;
        t = v[15:0];
`ifdef FFT2D_CTRL_SCALE_EN
        t = t >>> 1;
`endif
        return t;
    endfunction

    // Separable reference: row DFT on real data, then complex column DFT, each stage stored at 16 bits.
    task automatic ref_fft(input vec_t x, output vec_t ore, output vec_t oim);
        int   twr [4] = '{1, 0, -1, 0};
        int   twi [4] = '{0, -1, 0, 1};
        vec_t yr, yi;
        int   sr, si, m, a, b;
        for (int rr = 0; rr < 4; rr++)
            for (int k = 0; k < 4; k++) begin
                sr = 0; si = 0;
                for (int n = 0; n < 4; n++) begin
                    m  = (n * k) % 4;
                    sr += int'(x[rr*4+n]) * twr[m];
                    si += int'(x[rr*4+n]) * twi[m];
                end
                yr[rr*4+k] = sc16(sr);
                yi[rr*4+k] = sc16(si);
            end
        for (int cc = 0; cc < 4; cc++)
            for (int u = 0; u < 4; u++) begin
                sr = 0; si = 0;
                for (int n = 0; n < 4; n++) begin
                    m  = (n * u) % 4;
                    a  = int'(yr[n*4+cc]);
                    b  = int'(yi[n*4+cc]);
                    sr += a * twr[m] - b * twi[m];
                    si += a * twi[m] + b * twr[m];
                end
                ore[u*4+cc] = sc16(sr);
                oim[u*4+cc] = sc16(si);
            end
    endtask

    // Called at a negedge while in LOAD; returns at the negedge right after the 16th sample's accepting edge.
    task automatic send_frame(input vec_t x, input vec_t er, input vec_t ei, input bit tog);
        int i = 0;
        int guard = 0;
        bit ph = 1'b1;
        while (i < 16 && guard < 400) begin
            sif.in_valid = tog ? ph : 1'b1;
            ph = !ph;
            sif.in_data = x[i];
            if (sif.in_valid && sif.in_ready) begin
                i++;
                if (i == 16)
                    for (int k = 0; k < 16; k++) sb.push_back('{er[k], ei[k], (k == 15)});
            end
            @(negedge clk);
            guard++;
        end
        sif.in_valid = 1'b0;
        if (i < 16) check("load_timeout", i, 16);
    endtask

    task automatic check_beat(input int b, input bit pop);
        beat_t e;
        if (sb.size() == 0) begin
            check($sformatf("sb_empty_b%0d", b), 0, 1);
            return;
        end
        e = sb[0];
        check($sformatf("valid_b%0d", b), int'(sif.out_valid), 1);
        check($sformatf("real_b%0d", b), int'($signed(sif.out_real)), int'($signed(e.re)));
        check($sformatf("imag_b%0d", b), int'($signed(sif.out_imag)), int'($signed(e.im)));
        check($sformatf("last_b%0d", b), int'(sif.out_last), int'(e.last));
        if (pop) void'(sb.pop_front());
    endtask

    task automatic wait_first_valid();
        int lat = 0;
        while (!sif.out_valid && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        check("first_valid_latency", lat, 24);
    endtask

    task automatic recv_frame(input bit stall);
        int n;
        for (int b = 0; b < 16; b++) begin
            n = (stall && (b == 0 || b == 7 || b == 15)) ? 3 : 0;
            for (int s = 0; s < n; s++) begin
                sif.out_ready = 1'b0;
                check_beat(b, 1'b0);
                @(negedge clk);
            end
            sif.out_ready = 1'b1;
            check_beat(b, 1'b1);
            if (b == 15) check("in_ready_during_out", int'(sif.in_ready), 0);
            @(negedge clk);
        end
        check("in_ready_after_last", int'(sif.in_ready), 1);
        check("busy_after_last", int'(busy), 0);
        check("valid_after_last", int'(sif.out_valid), 0);
    endtask

    task automatic run_frame(input int k);
        send_frame(recs[k].x, recs[k].er, recs[k].ei, recs[k].tog);
        wait_first_valid();
        recv_frame(recs[k].stall);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        vec_t rnd;
        // 0 impulse, 1 DC, 2 shifted impulse, 3 impulse under backpressure, 4 random
        for (int k = 0; k < 5; k++)
            for (int i = 0; i < 16; i++) recs[k].x[i] = '0;
        recs[0].x[0] = 16'sd1;
        for (int i = 0; i < 16; i++) recs[1].x[i] = 16'sd1;
        recs[2].x[1] = 16'sd1;
        recs[3].x[0] = 16'sd1;
        for (int i = 0; i < 16; i++) recs[4].x[i] = 16'($urandom_range(0, 400)) - 16'sd200;
        for (int k = 0; k < 5; k++) begin
            recs[k].tog   = (k == 3);
            recs[k].stall = (k == 3);
            ref_fft(recs[k].x, recs[k].er, recs[k].ei);
        end

        // Reset with a sample offered: it must not be taken.
        rst_n         = 1'b0;
        sif.in_valid  = 1'b1;
        sif.in_data   = 16'h0077;
        sif.out_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_in_ready", int'(sif.in_ready), 1);
        check("rst_busy", int'(busy), 0);
        check("rst_out_valid", int'(sif.out_valid), 0);
        check("rst_out_last", int'(sif.out_last), 0);
        check("rst_out_real", int'(sif.out_real), 0);
        check("rst_out_imag", int'(sif.out_imag), 0);
        check("rst_eng_a", int'(eng_a0 | eng_a1 | eng_a2 | eng_a3), 0);
        rst_n        = 1'b1;
        sif.in_valid = 1'b0;
        @(negedge clk);

        for (int k = 0; k < 5; k++) run_frame(k);

        // Abort in CRE_CAP: acceptance edge + 9 edges.
        rnd = recs[4].x;
        send_frame(rnd, recs[4].er, recs[4].ei, 1'b0);
        repeat (9) @(negedge clk);
        check("abort_busy_before", int'(busy), 1);
        check("abort_eng_a0_before", int'($signed(eng_a0)), int'(recs[4].x[0]) + int'(recs[4].x[1]) + int'(recs[4].x[2]) + int'(recs[4].x[3]));
        rst_n = 1'b0;
        #1;
        check("abort_in_ready", int'(sif.in_ready), 1);
        check("abort_busy", int'(busy), 0);
        check("abort_eng_a0", int'(eng_a0), 0);
        sb.delete();
        @(negedge clk);
        check("abort_hold_busy", int'(busy), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_frame(1);

        // Chaining: DC then impulse with out_ready high throughout.
        sif.out_ready = 1'b1;
        run_frame(1);
        run_frame(0);

        check("sb_drained", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
